// File: rtl/regfile_mp_pkg.sv
// Shared defaults and sequencer state encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned MEM_W        = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned ZERO_REG_DEF = 1;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer for regfile_mp: sweeps every entry to zero, one per cycle.
module rf_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we_c,
  output logic [ADDR_W-1:0] clr_addr_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RF_IDLE;
      cnt_q    <= '0;
      clr_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clr_busy <= (state_d == RF_CLEAR);
    end
  end

  // Counter wraps naturally on the last entry, which is also the exit condition.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_we_c   = 1'b0;
    clr_addr_c = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_we_c = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with arbitrated debug port and clear sweep.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = MEM_W,
  parameter int unsigned ADDR_W   = REG_W,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] rs,
  output logic [NREAD*DATA_W-1:0] rv,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [DATA_W-1:0]       indata,
  input  logic                    dbg_req,
  input  logic                    dbg_we,
  input  logic [ADDR_W-1:0]       dbg_addr,
  input  logic [DATA_W-1:0]       dbg_wdata,
  output logic                    dbg_ack,
  output logic [DATA_W-1:0]       dbg_rdata,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we_c;
  logic [ADDR_W-1:0] clr_addr_c;

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_we_c   (clr_we_c),
    .clr_addr_c (clr_addr_c)
  );

  // Entry 0 is never written under ZERO_REG, so it reads 0 without masking.
  logic idle_c, core_wr_c, dbg_acc_c, dbg_wr_c;
  assign idle_c    = !clr_busy;
  assign core_wr_c = we && idle_c && !((ZERO_REG != 0) && (rd == '0));
  assign dbg_acc_c = dbg_req && !dbg_ack && idle_c && !core_wr_c;
  assign dbg_wr_c  = dbg_acc_c && dbg_we && !((ZERO_REG != 0) && (dbg_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr_we_c)  mem[clr_addr_c] <= '0;
      if (core_wr_c) mem[rd]         <= indata;
      if (dbg_wr_c)  mem[dbg_addr]   <= dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_acc_c;
      if (dbg_acc_c && !dbg_we) dbg_rdata <= mem[dbg_addr];
    end
  end

  always_comb begin
    rv = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rv[i*DATA_W +: DATA_W] = mem[rs[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (core_wr_c && (rs[i*ADDR_W +: ADDR_W] == rd)) rv[i*DATA_W +: DATA_W] = indata;
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a behavioural model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rs = '0;
  logic [63:0] rv;
  logic        we = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] indata = '0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        clr_req = 1'b0;
  logic        clr_busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rv(rv), .we(we), .rd(rd), .indata(indata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: array contents, remaining sweep cycles, debug ack/data.
  logic [31:0] m [32];
  logic        m_ack;
  logic [31:0] m_rdata;
  int          m_left;
  int          m_ptr;
  logic        m_idle, m_cw, m_acc;

  assign m_idle = (m_left == 0);
  assign m_cw   = we && m_idle && (rd != 5'd0);
  assign m_acc  = dbg_req && !m_ack && m_idle && !m_cw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m[i] <= '0;
      m_ack   <= 1'b0;
      m_rdata <= '0;
      m_left  <= 0;
      m_ptr   <= 0;
    end else begin
      if (!m_idle) begin
        m[m_ptr] <= '0;
        m_ptr    <= (m_ptr + 1) % 32;
        m_left   <= m_left - 1;
      end else if (clr_req) begin
        m_left <= 32;
        m_ptr  <= 0;
      end
      if (m_cw) m[rd] <= indata;
      if (m_acc && dbg_we && dbg_addr != 5'd0) m[dbg_addr] <= dbg_wdata;
      if (m_acc && !dbg_we) m_rdata <= m[dbg_addr];
      m_ack <= m_acc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rv(input logic [4:0] a);
    logic [31:0] e;
    e = m[a];
`ifdef REGFILE_BYPASS_EN
    if (m_cw && a == rd) e = indata;
`endif
    return e;
  endfunction

  // Continuous compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("rv0", rv[31:0], exp_rv(rs[4:0]));
    chk("rv1", rv[63:32], exp_rv(rs[9:5]));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("clr_busy", 32'(clr_busy), 32'(m_left != 0));
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dbg_ack && n < 200);
    chk("dbg_ack_timeout", 32'(dbg_ack), 32'd1);
  endtask

  logic [31:0] last_v, old4;
  int          lat, busy_n;
  logic        rst_pulse;

  initial begin
    // Reset
    repeat (3) step();
    chk("reset_ack", 32'(dbg_ack), 32'd0);
    chk("reset_busy", 32'(clr_busy), 32'd0);
    chk("reset_rdata", dbg_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic core write/read and hardwired zero
    we = 1'b1; rd = 5'd5; indata = 32'hDEADBEEF;
    step();
    we = 1'b0; rs = {5'd0, 5'd5};
    #1 chk("rd5", rv[31:0], 32'hDEADBEEF);
    step();
    we = 1'b1; rd = 5'd0; indata = 32'h1234;
    step();
    we = 1'b0; rs = '0;
    #1 chk("zero_reg", rv[31:0], 32'd0);
    step();

    // Debug read starved by core writes
    we = 1'b1; rd = 5'd3;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    for (int k = 0; k < 5; k++) begin
      indata = $urandom;
      last_v = indata;
      step();
      chk("starved_ack", 32'(dbg_ack), 32'd0);
    end
    we = 1'b0;
    wait_ack(lat);
    chk("starved_lat", 32'(lat), 32'd1);
    chk("starved_rdata", dbg_rdata, last_v);
    dbg_req = 1'b0;
    step();
    chk("single_pulse", 32'(dbg_ack), 32'd0);

    // Debug write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hA5A5A5A5;
    wait_ack(lat);
    chk("dbgwr_lat", 32'(lat), 32'd1);
    dbg_req = 1'b0; rs = {5'd0, 5'd7};
    #1 chk("dbgwr_read", rv[31:0], 32'hA5A5A5A5);
    step();

    // Fill, sweep, dropped core write, ignored second clr_req
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; rd = 5'(i); indata = $urandom | 32'h1;
      step();
    end
    we = 1'b0; clr_req = 1'b1;
    busy_n = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      clr_req = 1'b0; we = 1'b0;
      if (!clr_busy) break;
      busy_n++;
      if (busy_n == 15) begin we = 1'b1; rd = 5'd9; indata = 32'hCAFEF00D; end
      if (busy_n == 16) clr_req = 1'b1;
    end
    chk("sweep_len", 32'(busy_n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rs = {5'(31 - i), 5'(i)};
      #1 chk("swept", rv[31:0], 32'd0);
      step();
    end

    // Reset mid-sweep with a pending debug request
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; rd = 5'(i); indata = $urandom | 32'h1;
      step();
    end
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd20;
    repeat (10) step();
    rs = {5'd25, 5'd20};
    rst_n = 1'b0;
    #1 chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_entry", rv[31:0], 32'd0);
    chk("rst_entry2", rv[63:32], 32'd0);
    dbg_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_noack", 32'(dbg_ack), 32'd0);

    // Same-cycle forwarding
    we = 1'b1; rd = 5'd4; indata = 32'h77;
    step();
    old4 = 32'h77;
    indata = 32'h55; rs = {5'd0, 5'd4};
`ifdef REGFILE_BYPASS_EN
    #1 chk("bypass", rv[31:0], 32'h55);
`else
    #1 chk("bypass", rv[31:0], old4);
`endif
    step();
    we = 1'b0;
    #1 chk("after_wr4", rv[31:0], 32'h55);
    step();

    // Randomized traffic
    rst_pulse = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst_pulse) begin rst_n = 1'b1; rst_pulse = 1'b0; end
      we      = ($urandom_range(0, 2) == 0);
      rd      = 5'($urandom);
      indata  = $urandom;
      rs      = 10'($urandom);
      clr_req = ($urandom_range(0, 299) == 0);
      if (dbg_req && dbg_ack) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req   = 1'b1;
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 5'($urandom);
        dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0; rst_pulse = 1'b1; dbg_req = 1'b0;
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
